tlb_maint_unit: RTL and testbench

//  Sequencer for TLB maintenance ops: TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB. Issued by the commit stage.

---
 rtl/tlb_maint_unit_if.sv | 77 +++++++
 rtl/tlb_maint_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_tlb_maint_unit.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_maint_unit_if.sv
`default_nettype none
//==============================================================================
// Module  : tlb_maint_pkg / tlb_maint_if
// Brief   : TLB entry types and the commit-stage request/response bus.
// Revision: 1.0 - initial release
//==============================================================================

`ifndef _TLB_ENTRY_NUM
`define _TLB_ENTRY_NUM 16
`endif

package tlb_maint_pkg;

    localparam int TLB_NUM = `_TLB_ENTRY_NUM;
    localparam int TLB_IW  = $clog2(TLB_NUM);

    typedef struct packed {
        logic        e;
        logic [9:0]  asid;
        logic        g;
        logic        huge_page;
        logic [18:0] vppn;
    } tlb_key_t;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_data_t;

    typedef struct packed {
        tlb_key_t  key;
        tlb_data_t data0;
        tlb_data_t data1;
    } tlb_entry_t;

    typedef struct packed {
        logic [TLB_NUM-1:0] tlb_write_req;
        tlb_entry_t         tlb_write_entry;
    } tlb_write_req_t;

endpackage

interface tlb_maint_if;
    import tlb_maint_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [TLB_IW-1:0] req_idx;
    tlb_entry_t        req_entry;
    logic [9:0]        srch_asid;
    logic [18:0]       srch_vppn;
    logic [4:0]        inv_op;
    logic [31:0]       inv_va;

    logic              resp_valid;
    logic              resp_hit;
    logic [TLB_IW-1:0] resp_idx;
    tlb_entry_t        resp_entry;
    logic              resp_ine;

    modport master (
        output req_valid, req_op, req_idx, req_entry, srch_asid, srch_vppn, inv_op, inv_va,
        input  req_ready, resp_valid, resp_hit, resp_idx, resp_entry, resp_ine
    );

    modport slave (
        input  req_valid, req_op, req_idx, req_entry, srch_asid, srch_vppn, inv_op, inv_va,
        output req_ready, resp_valid, resp_hit, resp_idx, resp_entry, resp_ine
    );

endinterface

`default_nettype wire

// File: rtl/tlb_maint_unit.sv
`default_nettype none
//==============================================================================
// Module  : tlb_maint_unit
// Brief   : Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB maintenance ops.
// Revision: 1.0 - initial release
//==============================================================================

module tlb_maint_unit
    import tlb_maint_pkg::*;
#(
    parameter int TLB_ENTRY_NUM = TLB_NUM
) (
    input  wire logic                              clk,
    input  wire logic                              rst_n,
    tlb_maint_if.slave                             bus,
    output logic [$clog2(TLB_ENTRY_NUM)-1:0]       o_rd_idx,
    input  tlb_entry_t                             i_rd_entry,
    output tlb_write_req_t                         o_tlb_write_req
);

    localparam int              c_IW   = $clog2(TLB_ENTRY_NUM);
    localparam logic [c_IW-1:0] c_LAST = '1;

    localparam logic [2:0] c_OP_SRCH = 3'd0;
    localparam logic [2:0] c_OP_RD   = 3'd1;
    localparam logic [2:0] c_OP_WR   = 3'd2;
    localparam logic [2:0] c_OP_FILL = 3'd3;
    localparam logic [2:0] c_OP_INV  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_SCAN  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t          r_state,      w_nxt_state;
    logic [c_IW-1:0] r_scan_idx,   w_nxt_scan_idx;
    logic            r_ready,      w_nxt_ready;
    tlb_write_req_t  r_wr,         w_nxt_wr;
    logic            r_resp_valid, w_nxt_resp_valid;
    logic            r_resp_hit,   w_nxt_resp_hit;
    logic [c_IW-1:0] r_resp_idx,   w_nxt_resp_idx;
    tlb_entry_t      r_resp_entry, w_nxt_resp_entry;
    logic            r_resp_ine,   w_nxt_resp_ine;

    logic [c_IW-1:0] r_fill_ctr;
    logic [2:0]      r_op;
    logic [c_IW-1:0] r_idx;
    logic [9:0]      r_asid;
    logic [18:0]     r_vppn;
    logic [4:0]      r_inv_op;
    logic [18:0]     r_inv_vpn;

    logic            w_accept;
    logic [c_IW-1:0] w_wr_idx;
    logic            w_last;
    logic            w_asid_eq;
    logic            w_srch_match;
    logic            w_inv_match;
    tlb_entry_t      w_clr_entry;
    logic            w_unused_va;

    function automatic logic [TLB_ENTRY_NUM-1:0] f_onehot(input logic [c_IW-1:0] idx);
        logic [TLB_ENTRY_NUM-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Huge pages only compare the upper 10 bits of the VPPN.
    function automatic logic f_vpn_eq(input tlb_key_t key, input logic [18:0] vpn);
        if (key.huge_page) begin
            return key.vppn[18:9] == vpn[18:9];
        end
        return key.vppn == vpn;
    endfunction

    assign w_accept    = r_ready && bus.req_valid;
    assign w_wr_idx    = (bus.req_op == c_OP_FILL) ? r_fill_ctr : bus.req_idx;
    assign w_last      = (r_scan_idx == c_LAST);
    assign w_asid_eq   = (i_rd_entry.key.asid == r_asid);
    assign w_unused_va = ^bus.inv_va[12:0];

    assign w_srch_match = i_rd_entry.key.e && (i_rd_entry.key.g || w_asid_eq)
                          && f_vpn_eq(i_rd_entry.key, r_vppn);

    always_comb begin
        w_inv_match = 1'b0;
        case (r_inv_op)
            5'd0, 5'd1: w_inv_match = 1'b1;
            5'd2:       w_inv_match = i_rd_entry.key.e && i_rd_entry.key.g;
            5'd3:       w_inv_match = i_rd_entry.key.e && !i_rd_entry.key.g;
            5'd4:       w_inv_match = i_rd_entry.key.e && !i_rd_entry.key.g && w_asid_eq;
            5'd5:       w_inv_match = i_rd_entry.key.e && !i_rd_entry.key.g && w_asid_eq
                                      && f_vpn_eq(i_rd_entry.key, r_inv_vpn);
            5'd6:       w_inv_match = i_rd_entry.key.e && (i_rd_entry.key.g || w_asid_eq)
                                      && f_vpn_eq(i_rd_entry.key, r_inv_vpn);
            default:    w_inv_match = 1'b0;
        endcase
    end

    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_scan_idx    = r_scan_idx;
        w_nxt_wr          = '0;
        w_nxt_resp_valid  = 1'b0;
        w_nxt_resp_hit    = 1'b0;
        w_nxt_resp_idx    = '0;
        w_nxt_resp_entry  = '0;
        w_nxt_resp_ine    = 1'b0;
        w_clr_entry       = i_rd_entry;
        w_clr_entry.key.e = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nxt_scan_idx = '0;
                    case (bus.req_op)
                        c_OP_WR, c_OP_FILL: begin
                            w_nxt_wr.tlb_write_req   = f_onehot(w_wr_idx);
                            w_nxt_wr.tlb_write_entry = bus.req_entry;
                            w_nxt_resp_valid         = 1'b1;
                            w_nxt_resp_idx           = w_wr_idx;
                            w_nxt_state              = S_WRITE;
                        end
                        c_OP_RD:   w_nxt_state = S_READ;
                        c_OP_SRCH: w_nxt_state = S_SCAN;
                        c_OP_INV: begin
                            if (bus.inv_op > 5'd6) begin
                                w_nxt_resp_valid = 1'b1;
                                w_nxt_resp_ine   = 1'b1;
                                w_nxt_state      = S_RESP;
                            end else begin
                                w_nxt_state = S_SCAN;
                            end
                        end
                        default: begin
                            w_nxt_resp_valid = 1'b1;
                            w_nxt_resp_ine   = 1'b1;
                            w_nxt_state      = S_RESP;
                        end
                    endcase
                end
            end
            S_WRITE: w_nxt_state = S_IDLE;
            S_READ: begin
                w_nxt_resp_valid = 1'b1;
                w_nxt_resp_entry = i_rd_entry;
                w_nxt_state      = S_RESP;
            end
            S_SCAN: begin
                if (r_op == c_OP_SRCH) begin
                    if (w_srch_match || w_last) begin
                        w_nxt_resp_valid = 1'b1;
                        w_nxt_resp_hit   = w_srch_match;
                        w_nxt_resp_idx   = w_srch_match ? r_scan_idx : '0;
                        w_nxt_state      = S_RESP;
                    end else begin
                        w_nxt_scan_idx = r_scan_idx + c_IW'(1);
                    end
                end else begin
                    // Invalidate entry i while entry i+1 is being read.
                    if (w_inv_match) begin
                        w_nxt_wr.tlb_write_req   = f_onehot(r_scan_idx);
                        w_nxt_wr.tlb_write_entry = w_clr_entry;
                    end
                    if (w_last) begin
                        w_nxt_resp_valid = 1'b1;
                        w_nxt_state      = S_RESP;
                    end else begin
                        w_nxt_scan_idx = r_scan_idx + c_IW'(1);
                    end
                end
            end
            S_RESP:  w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    assign w_nxt_ready = (w_nxt_state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_scan_idx   <= '0;
            r_ready      <= 1'b0;
            r_wr         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_idx   <= '0;
            r_resp_entry <= '0;
            r_resp_ine   <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_scan_idx   <= w_nxt_scan_idx;
            r_ready      <= w_nxt_ready;
            r_wr         <= w_nxt_wr;
            r_resp_valid <= w_nxt_resp_valid;
            r_resp_hit   <= w_nxt_resp_hit;
            r_resp_idx   <= w_nxt_resp_idx;
            r_resp_entry <= w_nxt_resp_entry;
            r_resp_ine   <= w_nxt_resp_ine;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_ctr <= '0;
            r_op       <= '0;
            r_idx      <= '0;
            r_asid     <= '0;
            r_vppn     <= '0;
            r_inv_op   <= '0;
            r_inv_vpn  <= '0;
        end else begin
            r_fill_ctr <= r_fill_ctr + c_IW'(1);
            if (w_accept) begin
                r_op      <= bus.req_op;
                r_idx     <= bus.req_idx;
                r_asid    <= bus.srch_asid;
                r_vppn    <= bus.srch_vppn;
                r_inv_op  <= bus.inv_op;
                r_inv_vpn <= bus.inv_va[31:13];
            end
        end
    end

    assign o_rd_idx = (r_state == S_SCAN) ? r_scan_idx :
                      (r_state == S_READ) ? r_idx      : '0;

    assign o_tlb_write_req = r_wr;
    assign bus.req_ready   = r_ready;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_hit    = r_resp_hit;
    assign bus.resp_idx    = r_resp_idx;
    assign bus.resp_entry  = r_resp_entry;
    assign bus.resp_ine    = r_resp_ine;

endmodule

`default_nettype wire

// File: tb/tb_tlb_maint_unit.sv
`default_nettype none
//==============================================================================
// Module  : tb_tlb_maint_unit
// Brief   : Randomized bench for tlb_maint_unit against a cycle-offset model.
// Revision: 1.0 - initial release
//==============================================================================

module tb_tlb_maint_unit;
    import tlb_maint_pkg::*;

    localparam int N  = TLB_NUM;
    localparam int IW = TLB_IW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tlb_maint_if     bus();
    logic [IW-1:0]   rd_idx;
    tlb_entry_t      rd_entry;
    tlb_write_req_t  wreq;

    tlb_entry_t m_tlb [N];
    int         m_fill;
    int         n_checks = 0;
    int         n_fail   = 0;

    assign rd_entry = m_tlb[rd_idx];

    tlb_maint_unit #(.TLB_ENTRY_NUM(N)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .o_rd_idx        (rd_idx),
        .i_rd_entry      (rd_entry),
        .o_tlb_write_req (wreq)
    );

    // Free-running fill counter as the specification describes it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_fill <= 0;
        else        m_fill <= (m_fill + 1) % N;
    end

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit vpn_eq(input tlb_entry_t t, input logic [18:0] v);
        if (t.key.huge_page) return t.key.vppn[18:9] == v[18:9];
        return t.key.vppn == v;
    endfunction

    function automatic bit srch_hit(input tlb_entry_t t, input logic [9:0] asid, input logic [18:0] v);
        return t.key.e && (t.key.g || t.key.asid == asid) && vpn_eq(t, v);
    endfunction

    function automatic bit inv_hit(input tlb_entry_t t, input int op, input logic [9:0] asid,
                                   input logic [31:0] va);
        bit am, vm;
        am = (t.key.asid == asid);
        vm = vpn_eq(t, va[31:13]);
        case (op)
            0, 1: return 1'b1;
            2:    return t.key.e && t.key.g;
            3:    return t.key.e && !t.key.g;
            4:    return t.key.e && !t.key.g && am;
            5:    return t.key.e && !t.key.g && am && vm;
            6:    return t.key.e && (t.key.g || am) && vm;
            default: return 1'b0;
        endcase
    endfunction

    function automatic tlb_entry_t rand_entry();
        tlb_entry_t t;
        logic [18:0] pool [4];
        pool[0] = 19'h12345; pool[1] = 19'h00400; pool[2] = 19'h7FFFF; pool[3] = 19'($urandom);
        t.key.e         = ($urandom_range(0, 3) != 0);
        t.key.asid      = ($urandom_range(0, 1) != 0) ? 10'h2A : 10'($urandom);
        t.key.g         = ($urandom_range(0, 3) == 0);
        t.key.huge_page = ($urandom_range(0, 3) == 0);
        t.key.vppn      = pool[$urandom_range(0, 3)];
        {t.data0, t.data1} = 52'({$urandom, $urandom});
        return t;
    endfunction

    function automatic tlb_entry_t blank_entry();
        tlb_entry_t t;
        t = rand_entry();
        t.key.e = 1'b0;
        return t;
    endfunction

    task automatic fill_random();
        for (int j = 0; j < N; j++) m_tlb[j] = rand_entry();
    endtask

    // Issue one op and check every cycle until one past the response.
    task automatic do_op(input logic [2:0] op, input logic [IW-1:0] idx, input tlb_entry_t ent,
                         input logic [9:0] asid, input logic [18:0] vppn,
                         input logic [4:0] iop, input logic [31:0] va);
        logic [N-1:0]  exp_mask [N+4];
        tlb_entry_t    exp_went [N+4];
        int            resp_k, w, sel;
        logic          exp_hit, exp_ine, chk_ready, chk_idx;
        logic [IW-1:0] exp_idx, exp_rd;
        tlb_entry_t    exp_rent, tmp;
        for (int k = 0; k < N + 4; k++) begin exp_mask[k] = '0; exp_went[k] = '0; end
        exp_hit = 0; exp_ine = 0; chk_ready = 0; chk_idx = 0; exp_idx = '0; exp_rent = '0;
        exp_rd = '0; sel = 0;

        w = 0;
        while (bus.req_ready !== 1'b1 && w < 40) begin @(negedge clk); w++; end
        if (bus.req_ready !== 1'b1) begin
            check_eq("ready_timeout", 128'(bus.req_ready), 128'(1));
            return;
        end

        case (op)
            3'd2, 3'd3: begin
                sel = (op == 3'd2) ? int'(idx) : m_fill;
                exp_mask[1] = '0; exp_mask[1][sel] = 1'b1;
                exp_went[1] = ent;
                resp_k = 1; exp_idx = IW'(sel); chk_idx = 1; chk_ready = 1;
            end
            3'd1: begin
                resp_k = 2; exp_rent = m_tlb[idx]; exp_rd = idx;
            end
            3'd0: begin
                resp_k = 1 + N; chk_idx = 1;
                for (int j = N - 1; j >= 0; j--)
                    if (srch_hit(m_tlb[j], asid, vppn)) begin resp_k = 2 + j; exp_hit = 1; exp_idx = IW'(j); end
            end
            3'd4: begin
                if (iop > 5'd6) begin
                    resp_k = 1; exp_ine = 1;
                end else begin
                    resp_k = 1 + N; chk_ready = 1;
                    for (int j = 0; j < N; j++)
                        if (inv_hit(m_tlb[j], int'(iop), asid, va)) begin
                            exp_mask[2 + j][j] = 1'b1;
                            tmp = m_tlb[j]; tmp.key.e = 1'b0;
                            exp_went[2 + j] = tmp;
                        end
                end
            end
            default: begin resp_k = 1; exp_ine = 1; end
        endcase

        bus.req_op = op; bus.req_idx = idx; bus.req_entry = ent; bus.srch_asid = asid;
        bus.srch_vppn = vppn; bus.inv_op = iop; bus.inv_va = va; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;

        for (int k = 1; k <= resp_k + 1; k++) begin
            @(negedge clk);
            check_eq("strobe", 128'(wreq.tlb_write_req), 128'(exp_mask[k]));
            if (exp_mask[k] != '0)
                check_eq("wr_entry", 128'(wreq.tlb_write_entry), 128'(exp_went[k]));
            check_eq("resp_valid", 128'(bus.resp_valid), 128'(k == resp_k));
            if (k == 1) begin
                check_eq("ready_busy", 128'(bus.req_ready), 128'(0));
                if (op == 3'd1) check_eq("rd_idx", 128'(rd_idx), 128'(exp_rd));
                if (op == 3'd0 || (op == 3'd4 && iop <= 5'd6)) check_eq("scan_start", 128'(rd_idx), 128'(0));
            end
            if (k == resp_k) begin
                check_eq("resp_ine", 128'(bus.resp_ine), 128'(exp_ine));
                if (op == 3'd0) check_eq("resp_hit", 128'(bus.resp_hit), 128'(exp_hit));
                if (chk_idx)    check_eq("resp_idx", 128'(bus.resp_idx), 128'(exp_idx));
                if (op == 3'd1) check_eq("resp_entry", 128'(bus.resp_entry), 128'(exp_rent));
            end
            if (k == resp_k + 1 && chk_ready)
                check_eq("ready_back", 128'(bus.req_ready), 128'(1));
        end

        if (op == 3'd2 || op == 3'd3) m_tlb[sel] = ent;
        if (op == 3'd4 && iop <= 5'd6)
            for (int j = 0; j < N; j++)
                if (exp_mask[2 + j] != '0) m_tlb[j].key.e = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tlb_entry_t    e;
        logic [2:0]    op;
        logic [9:0]    asid;
        logic [18:0]   vppn;
        logic [4:0]    iop;
        int            w;

        bus.req_valid = 0; bus.req_op = '0; bus.req_idx = '0; bus.req_entry = '0;
        bus.srch_asid = '0; bus.srch_vppn = '0; bus.inv_op = '0; bus.inv_va = '0;
        fill_random();

        repeat (3) @(negedge clk);
        check_eq("rst_ready", 128'(bus.req_ready), 128'(0));
        check_eq("rst_resp", 128'(bus.resp_valid), 128'(0));
        check_eq("rst_strobe", 128'(wreq), 128'(0));
        check_eq("rst_rd_idx", 128'(rd_idx), 128'(0));
        rst_n = 1'b1;

        e = rand_entry(); e.key.vppn = 19'h12345;
        do_op(3'd2, IW'(5), e, 10'h0, 19'h0, 5'd0, 32'h0);

        for (int j = 0; j < N; j++) m_tlb[j] = blank_entry();
        m_tlb[3].key.e = 1; m_tlb[3].key.huge_page = 1; m_tlb[3].key.g = 1; m_tlb[3].key.vppn = 19'h00400;
        m_tlb[7].key.e = 1; m_tlb[7].key.huge_page = 0; m_tlb[7].key.g = 1; m_tlb[7].key.vppn = 19'h00400;
        do_op(3'd0, '0, '0, 10'h11, 19'h00400, 5'd0, 32'h0);
        do_op(3'd0, '0, '0, 10'h11, 19'h55555, 5'd0, 32'h0);

        for (int j = 0; j < N; j++) m_tlb[j] = blank_entry();
        m_tlb[1].key.e = 1; m_tlb[1].key.asid = 10'h2A; m_tlb[1].key.g = 0;
        m_tlb[2].key.e = 1; m_tlb[2].key.asid = 10'h2A; m_tlb[2].key.g = 1;
        m_tlb[9].key.e = 1; m_tlb[9].key.asid = 10'h2B; m_tlb[9].key.g = 0;
        do_op(3'd4, '0, '0, 10'h2A, 19'h0, 5'd4, 32'h0);
        do_op(3'd4, '0, '0, 10'h2A, 19'h0, 5'd7, 32'h0);
        do_op(3'd4, '0, '0, 10'h2A, 19'h0, 5'd0, 32'h0);
        do_op(3'd6, '0, '0, 10'h0, 19'h0, 5'd0, 32'h0);

        w = 0;
        while (m_fill != N - 3 && w < 2 * N) begin @(negedge clk); w++; end
        for (int r = 0; r < 3; r++) do_op(3'd3, '0, rand_entry(), 10'h0, 19'h0, 5'd0, 32'h0);

        for (int it = 0; it < 60; it++) begin
            if (it % 10 == 0) fill_random();
            e    = m_tlb[$urandom_range(0, N - 1)];
            op   = 3'($urandom_range(0, 7));
            asid = ($urandom_range(0, 2) != 0) ? e.key.asid : 10'($urandom);
            vppn = ($urandom_range(0, 2) != 0) ? e.key.vppn : 19'($urandom);
            iop  = 5'($urandom_range(0, 8));
            do_op(op, IW'($urandom), rand_entry(), asid, vppn, iop, {vppn, 13'($urandom)});
        end

        for (int j = 0; j < N; j++) begin m_tlb[j] = rand_entry(); m_tlb[j].key.e = 1; end
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 40) begin @(negedge clk); w++; end
        bus.req_op = 3'd4; bus.inv_op = 5'd0; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_eq("pre_rst_strobe", 128'(wreq.tlb_write_req), (k >= 2) ? (128'(1) << (k - 2)) : 128'(0));
        end
        rst_n = 1'b0;
        #1;
        check_eq("abort_strobe", 128'(wreq), 128'(0));
        check_eq("abort_resp", 128'(bus.resp_valid), 128'(0));
        check_eq("abort_ready", 128'(bus.req_ready), 128'(0));
        check_eq("abort_rd_idx", 128'(rd_idx), 128'(0));
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_hold_strobe", 128'(wreq.tlb_write_req), 128'(0));
        end
        rst_n = 1'b1;
        for (int k = 0; k < N + 4; k++) begin
            @(negedge clk);
            check_eq("post_rst_strobe", 128'(wreq.tlb_write_req), 128'(0));
            check_eq("post_rst_resp", 128'(bus.resp_valid), 128'(0));
        end
        check_eq("post_rst_idle", 128'(bus.req_ready), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
